sm_register_file_mp: RTL and testbench

SM_REGISTER_FILE_MP -- requirements
Module: sm_register_file_mp

---
 rtl/sm_register_file_mp.sv | 138 +++++++++++++
 tb/tb_sm_register_file_mp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sm_register_file_mp.sv
// sm_register_file_mp: NREGS x XLEN register file with three combinational
// read ports and two write ports (port B wins on address collision).
// Register 0 always reads as zero and ignores writes.
// After reset, a clear sweep zeroes registers 1..NREGS-1, one per cycle.
// While the sweep runs, busy is high, writes are ignored and reads return 0.
// Optional macro SM_RF_WRITE_BYPASS_EN forwards same-cycle write data to
// matching read ports. This applies only in IDLE, and port B has priority.
module sm_register_file_mp #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a0,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [XLEN-1:0]   rd0,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [XLEN-1:0]   wd3,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a4,
  input  logic [XLEN-1:0]   wd4,
  input  logic              we4,
  output logic              busy
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic [ADDR_W-1:0] raddr [3];
  logic [XLEN-1:0]   rdata [3];

  // Sweep sequencing: walk clr_idx up to the last register, then go idle.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        busy_d    = 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = FIRST_IDX;
        busy_d    = 1'b1;
      end
    endcase
  end

  // FSM state, sweep counter and busy flag; reset restarts the sweep at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= FIRST_IDX;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  // Next register contents: sweep clears one entry, idle applies B after A so B wins.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (state_q == ST_CLEAR) begin
      regs_d[clr_idx_q] = '0;
    end else begin
      if (we3 && (a3 != '0)) begin
        regs_d[a3] = wd3;
      end
      if (we4 && (a4 != '0)) begin
        regs_d[a4] = wd4;
      end
    end
    regs_d[0] = '0;
  end

  // Storage array; a reset edge discards whatever would have been written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign raddr[0] = a0;
  assign raddr[1] = a1;
  assign raddr[2] = a2;

  // Read ports: zero during the sweep and for address 0, optional write forwarding.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = '0;
      if ((state_q == ST_IDLE) && (raddr[p] != '0)) begin
        rdata[p] = regs_q[raddr[p]];
`ifdef SM_RF_WRITE_BYPASS_EN
        if (we3 && (a3 == raddr[p])) begin
          rdata[p] = wd3;
        end
        if (we4 && (a4 == raddr[p])) begin
          rdata[p] = wd4;
        end
`endif
      end
    end
  end

  assign rd0  = rdata[0];
  assign rd1  = rdata[1];
  assign rd2  = rdata[2];
  assign busy = busy_q;

endmodule

// File: tb/tb_sm_register_file_mp.sv
// tb_sm_register_file_mp: directed checks of sm_register_file_mp.
// Expectations follow SM_RF_WRITE_BYPASS_EN when it is defined for the build.
module tb_sm_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a0, a1, a2, a3, a4;
  logic [31:0] rd0, rd1, rd2, wd3, wd4;
  logic        we3, we4, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we4;
    logic [4:0]  a4;
    logic [31:0] wd4;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] nb0;
    logic [31:0] nb1;
    logic [31:0] nb2;
    logic [31:0] bp0;
    logic [31:0] bp1;
    logic [31:0] bp2;
  } vec_t;

  vec_t vecs [12];

  sm_register_file_mp #(.XLEN(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .a0  (a0),
    .a1  (a1),
    .a2  (a2),
    .rd0 (rd0),
    .rd1 (rd1),
    .rd2 (rd2),
    .a3  (a3),
    .wd3 (wd3),
    .we3 (we3),
    .a4  (a4),
    .wd4 (wd4),
    .we4 (we4),
    .busy(busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    we3 = v.we3; a3 = v.a3; wd3 = v.wd3;
    we4 = v.we4; a4 = v.a4; wd4 = v.wd4;
    a0 = v.a0; a1 = v.a1; a2 = v.a2;
  endtask

  // Count consecutive busy cycles starting in the current cycle.
  // Also count sweep cycles in which any read port was nonzero.
  task automatic countBusy(output int n, output logic firstBusy, output int rdNonZero);
    n = 0;
    rdNonZero = 0;
    firstBusy = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) firstBusy = busy;
      if (busy !== 1'b1) break;
      n++;
      if ((rd0 | rd1 | rd2) !== 32'h0) rdNonZero++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int   nBusy;
    int   nz;
    logic fb;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd6,  32'h12345678, 5'd1,  5'd2,  5'd0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  5'd0,
                 32'hDEADBEEF, 32'h12345678, 32'h0, 32'hDEADBEEF, 32'h12345678, 32'h0};
    vecs[2]  = '{1'b1, 5'd7,  32'h1111,     1'b1, 5'd7,  32'h2222,     5'd5,  5'd31, 5'd6,
                 32'hDEADBEEF, 32'h0, 32'h12345678, 32'hDEADBEEF, 32'h0, 32'h12345678};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  5'd7,
                 32'h0, 32'hDEADBEEF, 32'h2222, 32'h0, 32'hDEADBEEF, 32'h2222};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'h13572468, 5'd0,  5'd7,  5'd6,
                 32'h0, 32'h2222, 32'h12345678, 32'h0, 32'h2222, 32'h12345678};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 5'd7,
                 32'h0, 32'h0, 32'h2222, 32'h0, 32'h0, 32'h2222};
    vecs[6]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  5'd8,
                 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd8,  5'd9,  5'd0,
                 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};
    vecs[8]  = '{1'b1, 5'd10, 32'hBEEF,     1'b1, 5'd9,  32'hCAFE,     5'd9,  5'd10, 5'd9,
                 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'hCAFE, 32'hBEEF, 32'hCAFE};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd10, 5'd31,
                 32'hCAFE, 32'hBEEF, 32'h0, 32'hCAFE, 32'hBEEF, 32'h0};
    vecs[10] = '{1'b1, 5'd31, 32'h77,       1'b1, 5'd31, 32'h88,       5'd31, 5'd30, 5'd0,
                 32'h0, 32'h0, 32'h0, 32'h88, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 5'd0,
                 32'h88, 32'h0, 32'h0, 32'h88, 32'h0, 32'h0};

    rst = 1'b1;
    we3 = 1'b0; a3 = '0; wd3 = '0;
    we4 = 1'b0; a4 = '0; wd4 = '0;
    a0 = 5'd3; a1 = 5'd17; a2 = 5'd31;

    // Reset for one edge, then time the sweep.
    @(posedge clk); #1;
    rst = 1'b0;
    countBusy(nBusy, fb, nz);
    checkOutput("busy_after_rst", {31'b0, fb}, 32'd1);
    checkOutput("sweep_len", nBusy, 32'd31);
    checkOutput("sweep_rd_forced_zero", nz, 32'd0);
    checkOutput("busy_idle", {31'b0, busy}, 32'd0);

    // Every register reads zero after the sweep.
    for (int i = 1; i < 32; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end
      a0 = 5'(i);
      @(negedge clk);
      checkOutput($sformatf("cleared_r%0d", i), rd0, 32'h0);
    end

    // Mid-sweep reset, with writes to register 3 during the sweep.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h55; a0 = 5'd3;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("busy_pre_cycle%0d", k), {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("busy_cycle10", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    countBusy(nBusy, fb, nz);
    checkOutput("restart_busy", {31'b0, fb}, 32'd1);
    checkOutput("restart_sweep_len", nBusy, 32'd31);
    checkOutput("restart_rd_forced_zero", nz, 32'd0);
    we3 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ignored_write_r3", rd0, 32'h0);

    // Table-driven idle-mode vectors.
    for (int v = 0; v < 12; v++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[v]);
      @(negedge clk);
`ifdef SM_RF_WRITE_BYPASS_EN
      checkOutput($sformatf("vec%0d_rd0", v), rd0, vecs[v].bp0);
      checkOutput($sformatf("vec%0d_rd1", v), rd1, vecs[v].bp1);
      checkOutput($sformatf("vec%0d_rd2", v), rd2, vecs[v].bp2);
`else
      checkOutput($sformatf("vec%0d_rd0", v), rd0, vecs[v].nb0);
      checkOutput($sformatf("vec%0d_rd1", v), rd1, vecs[v].nb1);
      checkOutput($sformatf("vec%0d_rd2", v), rd2, vecs[v].nb2);
`endif
      checkOutput($sformatf("vec%0d_busy", v), {31'b0, busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
